// File: rtl/lane_req_sequencer_pkg.sv
// Shared sizes, access types, crossbar request payload and sequencer state encoding.
package lane_req_sequencer_pkg;

  localparam int unsigned NUM_OF_VECTOR_REG = 4;
  localparam int unsigned VECTOR_REG_DEPTH  = 16;
  localparam int unsigned VECTOR_REG_WIDTH  = 32;
  localparam int unsigned AW                = $clog2(VECTOR_REG_DEPTH);
  localparam int unsigned PW                = $clog2(NUM_OF_VECTOR_REG);

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic                        vld;
    logic [PW-1:0]               vec_reg_ptr;
    logic [AW-1:0]               addr;
    access_type_e                access_type;
    logic [AW:0]                 access_length;
    logic [VECTOR_REG_WIDTH-1:0] data;
  } cntrl_req_t;

endpackage

// File: rtl/lane_req_sequencer_if.sv
// Command, write-data, crossbar and read-out signals of one lane sequencer.
interface lane_req_sequencer_if;
  import lane_req_sequencer_pkg::*;

  logic                        cmd_vld;
  logic                        cmd_rdy;
  logic [PW-1:0]               cmd_vec_reg_ptr;
  logic [AW-1:0]               cmd_addr;
  logic [AW:0]                 cmd_len;
  access_type_e                cmd_type;
  logic                        wr_data_vld;
  logic [VECTOR_REG_WIDTH-1:0] wr_data;
  logic                        wr_data_rdy;
  cntrl_req_t                  vec_reg_req;
  logic                        reg_req_grant;
  logic                        rsp_vld;
  logic [VECTOR_REG_WIDTH-1:0] rd_data;
  logic                        rd_out_vld;
  logic [VECTOR_REG_WIDTH-1:0] rd_out_data;
  logic                        busy;
  logic                        done;

  // Sequencer side
  modport master (
    input  cmd_vld, cmd_vec_reg_ptr, cmd_addr, cmd_len, cmd_type,
    input  wr_data_vld, wr_data, reg_req_grant, rsp_vld, rd_data,
    output cmd_rdy, wr_data_rdy, vec_reg_req, rd_out_vld, rd_out_data, busy, done
  );

  // Command source / crossbar side
  modport slave (
    output cmd_vld, cmd_vec_reg_ptr, cmd_addr, cmd_len, cmd_type,
    output wr_data_vld, wr_data, reg_req_grant, rsp_vld, rd_data,
    input  cmd_rdy, wr_data_rdy, vec_reg_req, rd_out_vld, rd_out_data, busy, done
  );

endinterface

// File: rtl/lane_req_sequencer.sv
// Breaks a vector command into one crossbar request per element, re-arbitrating
// an element until it is granted; at most one element every two cycles.
module lane_req_sequencer
  import lane_req_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  lane_req_sequencer_if.master bus
);

  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  seq_state_t                  state;
  seq_state_t                  state_nxt;
  logic [PW-1:0]               cur_ptr;
  logic [AW-1:0]               cur_addr;
  logic [AW:0]                 remaining;
  access_type_e                cur_type;
  logic                        zero_done_q;
  logic                        rd_out_vld_q;
  logic [VECTOR_REG_WIDTH-1:0] rd_out_data_q;
  cntrl_req_t                  req_c;

  logic cmd_take;
  logic cmd_empty;
  logic elem_go;
  logic elem_done;
  logic last_elem;
  logic rd_capture;

  // Handshake qualifiers shared by the FSM and the datapath
  assign cmd_take   = (state == IDLE) && bus.cmd_vld;
  assign cmd_empty  = (bus.cmd_len == '0);
  assign elem_go    = (state == ISSUE) && ((cur_type == READ_REQ) || bus.wr_data_vld);
  assign elem_done  = (state == WAIT) && bus.reg_req_grant;
  assign last_elem  = (remaining <= LEN_ONE);
  assign rd_capture = (state == WAIT) && bus.rsp_vld && (cur_type == READ_REQ);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a request always drops for one cycle while the grant is awaited
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_take && !cmd_empty) state_nxt = ISSUE;
      ISSUE:   if (elem_go) state_nxt = WAIT;
      WAIT:    state_nxt = (elem_done && last_elem) ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command context, element progress and the registered read-out path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_ptr       <= '0;
      cur_addr      <= '0;
      remaining     <= '0;
      cur_type      <= READ_REQ;
      zero_done_q   <= 1'b0;
      rd_out_vld_q  <= 1'b0;
      rd_out_data_q <= '0;
    end else begin
      zero_done_q  <= cmd_take && cmd_empty;
      rd_out_vld_q <= rd_capture;
      if (rd_capture) begin
        rd_out_data_q <= bus.rd_data;
      end
      if (cmd_take && !cmd_empty) begin
        cur_ptr   <= bus.cmd_vec_reg_ptr;
        cur_addr  <= bus.cmd_addr;
        remaining <= bus.cmd_len;
        cur_type  <= bus.cmd_type;
      end else if (elem_done) begin
        cur_addr  <= cur_addr + AW'(1);
        remaining <= remaining - LEN_ONE;
      end
    end
  end

  // Outputs: request and write-consume follow the live handshake inputs
  always_comb begin
    req_c           = '0;
    bus.wr_data_rdy = 1'b0;
    bus.done        = zero_done_q;
    bus.cmd_rdy     = (state == IDLE);
    bus.busy        = (state != IDLE);
    bus.rd_out_vld  = rd_out_vld_q;
    bus.rd_out_data = rd_out_data_q;
    if (elem_go) begin
      req_c.vld           = 1'b1;
      req_c.vec_reg_ptr   = cur_ptr;
      req_c.addr          = cur_addr;
      req_c.access_type   = cur_type;
      req_c.access_length = remaining;
      req_c.data          = bus.wr_data;
    end
    if (elem_done) begin
      bus.wr_data_rdy = (cur_type == WRITE_REQ);
      if (last_elem) begin
        bus.done = 1'b1;
      end
    end
  end

  assign bus.vec_reg_req = req_c;

endmodule

// File: tb/tb_lane_req_sequencer.sv
module tb_lane_req_sequencer;
  import lane_req_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_req_sequencer_if bus_if();

  lane_req_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the outstanding command as "next element address / elements left"
  bit           active, prev_req, prev_rd, zero_done_pend, wr_consumed;
  logic [31:0]  prev_rd_data;
  int unsigned  exp_ptr, next_addr, elems_left;
  access_type_e exp_type;

  // Stimulus knobs: grant_mode 0=always 1=random 2=withhold first N; wr_mode likewise
  int           grant_mode, withhold, wr_mode, wr_hold;
  bit           noise_en, issue;
  int unsigned  iss_ptr, iss_addr, iss_len;
  access_type_e iss_type;
  logic [31:0]  wr_seq[$];

  // Observations for the directed scenarios
  int           cyc, cnt_req, cnt_done, cnt_wr_rdy, cnt_rd, first_req_cyc, accept_cyc;
  bit           last_done;
  int unsigned  obs_addr[$], obs_len[$];
  logic [31:0]  obs_data[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_cmd_rdy"}, 64'(bus_if.cmd_rdy), 64'(1));
    check_eq({tag, "_busy"},    64'(bus_if.busy), 64'(0));
    check_eq({tag, "_done"},    64'(bus_if.done), 64'(0));
    check_eq({tag, "_wr_rdy"},  64'(bus_if.wr_data_rdy), 64'(0));
    check_eq({tag, "_rd_vld"},  64'(bus_if.rd_out_vld), 64'(0));
    check_eq({tag, "_rd_data"}, 64'(bus_if.rd_out_data), 64'(0));
    check_eq({tag, "_req"},     64'(bus_if.vec_reg_req), 64'(0));
  endtask

  // One clock: drive at negedge, check 1ns later, then advance the model
  task automatic step();
    bit         g, was_active, exp_vld, exp_done, exp_wrdy;
    cntrl_req_t r;
    @(negedge clk);
    if (wr_consumed) begin
      wr_consumed = 1'b0;
      if (wr_seq.size() > 0) bus_if.wr_data = wr_seq.pop_front();
      else                   bus_if.wr_data = $urandom();
    end
    g = 1'b0;
    if (prev_req) begin
      case (grant_mode)
        0:       g = 1'b1;
        1:       g = 1'($urandom_range(0, 1));
        default: if (withhold > 0) begin withhold--; g = 1'b0; end else g = 1'b1;
      endcase
    end
    bus_if.reg_req_grant = g;
    bus_if.rsp_vld       = g;
    bus_if.rd_data       = $urandom();
    case (wr_mode)
      0:       bus_if.wr_data_vld = 1'b1;
      1:       bus_if.wr_data_vld = ($urandom_range(0, 3) != 0);
      default: if (wr_hold > 0) begin wr_hold--; bus_if.wr_data_vld = 1'b0; end
               else bus_if.wr_data_vld = 1'b1;
    endcase
    if (issue) begin
      bus_if.cmd_vld         = 1'b1;
      bus_if.cmd_vec_reg_ptr = PW'(iss_ptr);
      bus_if.cmd_addr        = AW'(iss_addr);
      bus_if.cmd_len         = (AW+1)'(iss_len);
      bus_if.cmd_type        = iss_type;
    end else if (noise_en && active) begin
      bus_if.cmd_vld         = 1'($urandom_range(0, 1));
      bus_if.cmd_vec_reg_ptr = PW'($urandom());
      bus_if.cmd_addr        = AW'($urandom());
      bus_if.cmd_len         = (AW+1)'($urandom_range(0, VECTOR_REG_DEPTH));
      bus_if.cmd_type        = access_type_e'(1'($urandom_range(0, 1)));
    end else begin
      bus_if.cmd_vld = 1'b0;
    end
    #1;
    was_active = active;
    exp_vld    = active && !prev_req && (exp_type == READ_REQ || bus_if.wr_data_vld);
    exp_done   = zero_done_pend || (g && active && elems_left == 1);
    exp_wrdy   = g && active && (exp_type == WRITE_REQ);
    r          = bus_if.vec_reg_req;

    check_eq("cmd_rdy", 64'(bus_if.cmd_rdy), 64'(!active));
    check_eq("busy", 64'(bus_if.busy), 64'(active));
    check_eq("done", 64'(bus_if.done), 64'(exp_done));
    check_eq("wr_data_rdy", 64'(bus_if.wr_data_rdy), 64'(exp_wrdy));
    check_eq("rd_out_vld", 64'(bus_if.rd_out_vld), 64'(prev_rd));
    if (prev_rd) check_eq("rd_out_data", 64'(bus_if.rd_out_data), 64'(prev_rd_data));
    check_eq("req_vld", 64'(r.vld), 64'(exp_vld));
    if (exp_vld && r.vld) begin
      check_eq("req_ptr",  64'(r.vec_reg_ptr), 64'(exp_ptr));
      check_eq("req_addr", 64'(r.addr), 64'(next_addr));
      check_eq("req_type", 64'(r.access_type), 64'(exp_type));
      check_eq("req_len",  64'(r.access_length), 64'(elems_left));
      if (exp_type == WRITE_REQ) check_eq("req_data", 64'(r.data), 64'(bus_if.wr_data));
    end

    if (r.vld) begin
      cnt_req++;
      obs_addr.push_back(32'(r.addr));
      obs_len.push_back(32'(r.access_length));
      obs_data.push_back(r.data);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (bus_if.done)        cnt_done++;
    if (bus_if.wr_data_rdy) cnt_wr_rdy++;
    if (bus_if.rd_out_vld)  cnt_rd++;
    last_done = bus_if.done;

    zero_done_pend = 1'b0;
    prev_rd        = g && active && (exp_type == READ_REQ);
    prev_rd_data   = bus_if.rd_data;
    if (g && active) begin
      if (exp_type == WRITE_REQ) wr_consumed = 1'b1;
      next_addr = (next_addr + 1) % VECTOR_REG_DEPTH;
      elems_left--;
      if (elems_left == 0) active = 1'b0;
    end
    if (bus_if.cmd_vld && !was_active) begin
      accept_cyc = cyc;
      if (bus_if.cmd_len == '0) begin
        zero_done_pend = 1'b1;
      end else begin
        active     = 1'b1;
        exp_ptr    = 32'(bus_if.cmd_vec_reg_ptr);
        next_addr  = 32'(bus_if.cmd_addr);
        elems_left = 32'(bus_if.cmd_len);
        exp_type   = bus_if.cmd_type;
      end
    end
    prev_req = exp_vld;
    cyc++;
  endtask

  // Offer one command, run until done (bounded), then one drain cycle for rd_out
  task automatic run_cmd(input int unsigned ptr, input int unsigned addr, input int unsigned len,
                         input access_type_e t, output int lat);
    bit seen;
    cnt_req = 0; cnt_done = 0; cnt_wr_rdy = 0; cnt_rd = 0; first_req_cyc = -1;
    obs_addr.delete(); obs_len.delete(); obs_data.delete();
    iss_ptr = ptr; iss_addr = addr; iss_len = len; iss_type = t;
    issue = 1'b1;
    step();
    issue = 1'b0;
    seen = 1'b0;
    lat  = -1;
    for (int n = 1; n < 2000 && !seen; n++) begin
      step();
      if (last_done) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    check_eq("done_seen", 64'(seen), 64'(1));
    step();
  endtask

  initial begin
    int lat;
    reset = 1'b0;
    bus_if.cmd_vld = 1'b0; bus_if.cmd_vec_reg_ptr = '0; bus_if.cmd_addr = '0;
    bus_if.cmd_len = '0; bus_if.cmd_type = READ_REQ; bus_if.wr_data_vld = 1'b0;
    bus_if.wr_data = '0; bus_if.reg_req_grant = 1'b0; bus_if.rsp_vld = 1'b0; bus_if.rd_data = '0;
    active = 0; prev_req = 0; prev_rd = 0; zero_done_pend = 0; wr_consumed = 0;
    grant_mode = 0; withhold = 0; wr_mode = 0; wr_hold = 0; noise_en = 0; issue = 0; cyc = 0;

    repeat (2) @(negedge clk);
    #1 check_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    // Read of three elements, always granted
    run_cmd(2, 5, 3, READ_REQ, lat);
    check_eq("rd3_latency", 64'(lat), 64'(6));
    check_eq("rd3_nreq", 64'(cnt_req), 64'(3));
    for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
      check_eq("rd3_addr", 64'(obs_addr[i]), 64'(5 + i));
      check_eq("rd3_len",  64'(obs_len[i]), 64'(3 - i));
    end
    check_eq("rd3_nrd", 64'(cnt_rd), 64'(3));
    check_eq("rd3_ndone", 64'(cnt_done), 64'(1));

    // Write across the top address: wraps to 0
    bus_if.wr_data = 32'hA;
    wr_seq.push_back(32'hB);
    run_cmd(1, VECTOR_REG_DEPTH - 1, 2, WRITE_REQ, lat);
    check_eq("wrap_nreq", 64'(cnt_req), 64'(2));
    if (obs_addr.size() == 2) begin
      check_eq("wrap_addr0", 64'(obs_addr[0]), 64'(VECTOR_REG_DEPTH - 1));
      check_eq("wrap_addr1", 64'(obs_addr[1]), 64'(0));
      check_eq("wrap_data0", 64'(obs_data[0]), 64'(32'hA));
      check_eq("wrap_data1", 64'(obs_data[1]), 64'(32'hB));
    end
    check_eq("wrap_nwrrdy", 64'(cnt_wr_rdy), 64'(2));
    check_eq("wrap_ndone", 64'(cnt_done), 64'(1));

    // Zero-length command
    run_cmd(0, 3, 0, READ_REQ, lat);
    check_eq("zero_latency", 64'(lat), 64'(1));
    check_eq("zero_nreq", 64'(cnt_req), 64'(0));
    check_eq("zero_ndone", 64'(cnt_done), 64'(1));

    // Grant withheld twice: same element re-requested
    grant_mode = 2; withhold = 2;
    run_cmd(3, 9, 1, READ_REQ, lat);
    check_eq("retry_nreq", 64'(cnt_req), 64'(3));
    foreach (obs_addr[i]) check_eq("retry_addr", 64'(obs_addr[i]), 64'(9));
    check_eq("retry_nrd", 64'(cnt_rd), 64'(1));
    check_eq("retry_ndone", 64'(cnt_done), 64'(1));
    grant_mode = 0;

    // Write data absent for four ISSUE cycles
    wr_mode = 2; wr_hold = 5;
    run_cmd(1, 0, 1, WRITE_REQ, lat);
    check_eq("stall_first_req", 64'(first_req_cyc - accept_cyc), 64'(5));
    check_eq("stall_nreq", 64'(cnt_req), 64'(1));
    check_eq("stall_nwrrdy", 64'(cnt_wr_rdy), 64'(1));
    wr_mode = 0;

    // Reset in the WAIT of element 2 of 4
    cnt_done = 0;
    iss_ptr = 1; iss_addr = 8; iss_len = 4; iss_type = READ_REQ;
    issue = 1'b1;
    step();
    issue = 1'b0;
    repeat (3) step();
    check_eq("pre_rst_waiting", 64'(prev_req), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    bus_if.reg_req_grant = 1'b0; bus_if.rsp_vld = 1'b0; bus_if.cmd_vld = 1'b0;
    #1 check_reset_vals("mid_rst");
    repeat (3) begin
      @(negedge clk);
      #1 check_reset_vals("mid_rst_hold");
    end
    @(negedge clk);
    reset = 1'b1;
    active = 0; prev_req = 0; prev_rd = 0; zero_done_pend = 0; wr_consumed = 0;
    repeat (3) step();
    check_eq("rst_no_done", 64'(cnt_done), 64'(0));
    run_cmd(2, 4, 2, WRITE_REQ, lat);
    check_eq("post_rst_nreq", 64'(cnt_req), 64'(2));
    check_eq("post_rst_ndone", 64'(cnt_done), 64'(1));

    // Random commands with random grants, data gaps and ignored busy-time offers
    grant_mode = 1; wr_mode = 1; noise_en = 1;
    repeat (40) begin
      run_cmd($urandom_range(0, NUM_OF_VECTOR_REG - 1), $urandom_range(0, VECTOR_REG_DEPTH - 1),
              $urandom_range(0, VECTOR_REG_DEPTH), access_type_e'(1'($urandom_range(0, 1))), lat);
      check_eq("rand_ndone", 64'(cnt_done), 64'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_req_sequencer.md
LANE_REQ_SEQUENCER -- requirements
Module: lane_req_sequencer

Interface
REQ-001 SHALL have no parameters; NUM_OF_VECTOR_REG, VECTOR_REG_DEPTH and VECTOR_REG_WIDTH come from the shared package (AW = $clog2(VECTOR_REG_DEPTH), PW = $clog2(NUM_OF_VECTOR_REG)).
REQ-002 SHALL use one clock, with reset asynchronous and active-low: clk  in  1  clock.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 cmd_vld  in  1  command offered.
REQ-005 cmd_rdy  out  1  command accepted when cmd_vld && cmd_rdy.
REQ-006 cmd_vec_reg_ptr  in  PW  target vector register.
REQ-007 cmd_addr  in  AW  first element address.
REQ-008 cmd_len  in  AW+1  element count, 0..VECTOR_REG_DEPTH.
REQ-009 cmd_type  in  package access-type enum  READ_REQ or WRITE_REQ.
REQ-010 wr_data_vld  in  1  write element available.
REQ-011 wr_data  in  VECTOR_REG_WIDTH  write element; held stable until consumed.
REQ-012 wr_data_rdy  out  1  one-cycle pulse when the write element is consumed.
REQ-013 vec_reg_req  out  cntrl_req_t  request to the crossbar (vld, vec_reg_ptr, addr, access_type, access_length, data).
REQ-014 reg_req_grant  in  1  crossbar grant, arriving 1 cycle after the granted request.
REQ-015 rsp_vld  in  1  crossbar response valid, coincident with reg_req_grant.
REQ-016 rd_data  in  VECTOR_REG_WIDTH  register read data, valid with rsp_vld.
REQ-017 rd_out_vld  out  1  read element delivered.
REQ-018 rd_out_data  out  VECTOR_REG_WIDTH  delivered read element.
REQ-019 busy  out  1  command in progress.
REQ-020 done  out  1  one-cycle pulse when a command completes.

Function
REQ-021 SHALL implement states IDLE, ISSUE and WAIT; cmd_rdy = (state == IDLE); busy = (state != IDLE).
REQ-022 On command accept with cmd_len == 0, the block SHALL remain in IDLE, pulse done the next cycle, and issue no request.
REQ-023 On command accept with cmd_len > 0, the block SHALL latch ptr, addr, type and len into cur_addr and remaining, then enter ISSUE.
REQ-024 In ISSUE, vec_reg_req.vld SHALL be 1 for exactly one cycle, with addr = cur_addr, access_length = remaining, and data = wr_data; the next state is WAIT.
REQ-025 For a WRITE command in ISSUE with wr_data_vld == 0, vld SHALL be 0 and the block SHALL stay in ISSUE (stall).
REQ-026 In WAIT, vld SHALL be 0; if reg_req_grant == 0, the block SHALL return to ISSUE (re-arbitrate the same element).
REQ-027 In WAIT with reg_req_grant == 1, the element is complete: the block SHALL set cur_addr = cur_addr + 1 (modulo VECTOR_REG_DEPTH) and remaining = remaining - 1.
REQ-028 After that update, the block SHALL enter ISSUE if remaining was greater than 1, else enter IDLE with done pulsed in the same cycle.
REQ-029 For WRITE, wr_data_rdy SHALL pulse in the WAIT cycle where reg_req_grant == 1.
REQ-030 For READ, in WAIT with rsp_vld == 1, rd_out_data <= rd_data and rd_out_vld SHALL pulse 1 cycle later.
REQ-031 Element throughput SHALL be at most 1 element per 2 cycles; the request is never held across a grant, which prevents duplicate grants.
REQ-032 Commands SHALL NOT be accepted outside IDLE; cmd_vld elsewhere SHALL be ignored.

Reset
REQ-033 While reset == 0: state = IDLE; vec_reg_req all-zero; cmd_rdy = 1; wr_data_rdy, rd_out_vld, done and busy = 0; rd_out_data = 0; remaining and cur_addr = 0.
REQ-034 Reset mid-command SHALL abandon the command with no done pulse and no further requests.

Structure
REQ-035 cntrl_req_t, the access-type enum (READ_REQ, WRITE_REQ), the size constants and a new seq_state_t SHALL reside in the shared package.
REQ-036 The block SHALL be a single module with no sub-module.

Verification
REQ-037 READ, ptr=2, addr=5, len=3, grant on every WAIT -> requests at addr 5,6,7 with access_length 3,2,1; 3 rd_out_vld pulses; done on the 6th cycle after accept.
REQ-038 WRITE, addr=VECTOR_REG_DEPTH-1, len=2, wr_data 0xA then 0xB -> addrs DEPTH-1 then 0 (wrap); 2 wr_data_rdy pulses; done.
REQ-039 len=0 -> no vld, done pulse 1 cycle after accept.
REQ-040 Grant withheld on first 2 WAITs, len=1 -> 3 ISSUE pulses at the same addr; exactly 1 completion.
REQ-041 WRITE with wr_data_vld=0 for 4 cycles -> vld stays 0, state ISSUE; proceeds when wr_data_vld=1.
REQ-042 Reset asserted in WAIT of element 2 of 4 -> all outputs at reset values; no done; next command runs normally.
